// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus output stream of the burst reader, bundled as one interface.
// The master modport is the reader; the slave modport is the FIFO/sink side.
interface fifo_burst_reader_if #(
    parameter int WIDTH = 32,
    parameter int DLOG2 = 3
);
    logic             fifo_empty;
    logic [DLOG2-1:0] fifo_usedw;
    logic [WIDTH-1:0] fifo_q;
    logic             fifo_rdreq;
    logic             flush;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;

    modport master (
        input  fifo_empty, fifo_usedw, fifo_q, flush, out_ready,
        output fifo_rdreq, out_data, out_valid, out_last, busy
    );

    modport slave (
        output fifo_empty, fifo_usedw, fifo_q, flush, out_ready,
        input  fifo_rdreq, out_data, out_valid, out_last, busy
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Burst read controller for a synchronous FIFO with 1-cycle read latency,
// presenting words as a valid/ready stream with a last tag per burst/drain.
module fifo_burst_reader #(
    parameter int WIDTH = 32,
    parameter int DLOG2 = 3,
    parameter int BURST = 4
) (
    input  logic                 clock,
    input  logic                 aclr,
    fifo_burst_reader_if.master  bus
);
    localparam logic [DLOG2:0]   BURST_C = (DLOG2+1)'(BURST);
    localparam logic [DLOG2:0]   RCNT_ONE = (DLOG2+1)'(1);
    localparam logic [DLOG2-1:0] USED_ONE = DLOG2'(1);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [DLOG2:0]   rcnt_q, rcnt_d;
    logic             inflight_q, inflight_last_q;
    logic             rd_ptr_q, wr_ptr_q;
    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] buf_data_q [2];
    logic             buf_last_q [2];

    logic             rdreq, rd_last, pop, out_valid;
    logic             bypass, buf_wr, buf_rd;
    logic [WIDTH-1:0] head_data;
    logic             head_last;

    // The word arriving from the FIFO is the head when the buffer is empty,
    // which gives the two-cycle trigger-to-valid latency.
    always_comb begin
        out_valid = (occ_q != 2'd0) | inflight_q;
        head_data = (occ_q != 2'd0) ? buf_data_q[rd_ptr_q] : bus.fifo_q;
        head_last = (occ_q != 2'd0) ? buf_last_q[rd_ptr_q] : inflight_last_q;
        pop       = out_valid & bus.out_ready;
        bypass    = inflight_q & (occ_q == 2'd0) & pop;
        buf_wr    = inflight_q & ~bypass;
        buf_rd    = pop & (occ_q != 2'd0);
        // Words committed to the 2-entry buffer after this edge, before any new read.
        occ_d     = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        rdreq     = (state_q != S_IDLE) & ~bus.fifo_empty & (occ_d < 2'd2);
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rd_last = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ({1'b0, bus.fifo_usedw} >= BURST_C) begin
                    state_d = S_BURST;
                    rcnt_d  = BURST_C;
                end else if (bus.flush && !bus.fifo_empty) begin
                    state_d = S_DRAIN;
                end
            end
            S_BURST: begin
                rd_last = (rcnt_q == RCNT_ONE);
                if (rdreq) begin
                    rcnt_d = rcnt_q - RCNT_ONE;
                    if (rcnt_q == RCNT_ONE) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                rd_last = (bus.fifo_usedw == USED_ONE);
                if (rdreq && bus.fifo_usedw == USED_ONE) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state_q         <= S_IDLE;
            rcnt_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            occ_q           <= 2'd0;
        end else begin
            state_q         <= state_d;
            rcnt_q          <= rcnt_d;
            inflight_q      <= rdreq;
            inflight_last_q <= rdreq & rd_last;
            occ_q           <= occ_d;
            if (buf_wr) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (buf_rd) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
        always_ff @(posedge clock or posedge aclr) begin
            if (aclr) begin
                buf_data_q[gi] <= '0;
                buf_last_q[gi] <= 1'b0;
            end else if (buf_wr && wr_ptr_q == 1'(gi)) begin
                buf_data_q[gi] <= bus.fifo_q;
                buf_last_q[gi] <= inflight_last_q;
            end
        end
    end

    assign bus.fifo_rdreq = rdreq;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = out_valid ? head_data : '0;
    assign bus.out_last   = out_valid & head_last;
    assign bus.busy       = (state_q != S_IDLE) | inflight_q | (occ_q != 2'd0);
endmodule
